if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register. Holds the PC, issues requests to a variable-latency instruction memory, selects the next PC among sequential/branch/jump/exception, and drives the IF/ID inputs (PC+4, instruction) plus its flush line. Because the IF/ID register has no enable, this block implements stall holding with a one-entry buffer, and inserts NOP bubbles (all-zero word, PC+4 = 0).

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- EXC_VECTOR, 32'h8000_0180, exception/timeout redirect target
- TIMEOUT_CYCLES, 16, imem wait limit (used only with FETCH_TIMEOUT_EN)
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- stall  in  1  hazard unit: hold IF/ID contents
- exception  in  1  redirect to EXC_VECTOR
- jump  in  1  redirect to jump_target
- jump_target  in  32  jump destination
- branch_taken  in  1  redirect to branch_target
- branch_target  in  32  branch destination
- imem_req  out  1  request valid
- imem_addr  out  32  request address, stable while imem_req && !imem_ready
- imem_rdata  in  32  instruction, valid when imem_ready
- imem_ready  in  1  completes current request
- pc_add4_o  out  32  to IF/ID IPCAdd4 (registered)
- inst_o  out  32  to IF/ID IInst (registered)
- flush_o  out  1  to IF/ID CFlush (combinational)
- fetch_err_o  out  1  one-cycle timeout pulse

## Operation
- redirect = exception | jump | branch_taken; target priority exception > jump > branch. Redirect overrides stall in the same cycle.
- flush_o = redirect (| timeout when enabled), combinational.
- States: IDLE, WAIT, HOLD, DRAIN. Registers: fetch_addr (drives imem_addr), pend_target, buf_inst, buf_pc4.
- IDLE: imem_req=0; unconditionally -> WAIT next cycle.
- WAIT (imem_req=1):
  - redirect & imem_ready: discard rdata; fetch_addr<=target; stay WAIT; outputs<=bubble.
  - redirect & !imem_ready: pend_target<=target; -> DRAIN; outputs<=bubble.
  - imem_ready & !stall: inst_o<=rdata, pc_add4_o<=fetch_addr+4, fetch_addr<=fetch_addr+4; stay WAIT.
  - imem_ready & stall: buf<=rdata/fetch_addr+4, fetch_addr<=fetch_addr+4; outputs hold; -> HOLD.
  - !imem_ready: outputs hold if stall, else bubble.
- HOLD (imem_req=0): stall -> hold outputs; !stall -> outputs<=buf, -> WAIT; redirect -> drop buf, fetch_addr<=target, outputs<=bubble, -> WAIT.
- DRAIN (imem_req=1, old address): new redirect overwrites pend_target; on imem_ready discard rdata, fetch_addr<=pend_target, -> WAIT. Outputs bubble unless stall (hold).
- PC arithmetic: 32-bit, +4 wraps 32'hFFFF_FFFC -> 0; no alignment check.

## Timing
- Reset values: state IDLE, fetch_addr=RESET_PC, imem_req=0, pc_add4_o=0, inst_o=0, fetch_err_o=0, buffers 0; flush_o follows inputs.
- First request: imem_req=1 in 2nd cycle after reset release.
- Latency: imem_ready at cycle N -> inst_o valid at N+1 -> IF/ID captures at end of N+1.
- Zero-wait memory sustains one instruction per cycle.
- Redirect at cycle N: new target on imem_addr at N+1 (if no outstanding request), else cycle after outstanding completes.
- Reset mid-request: outstanding request abandoned; memory is reset with the same signal.

## Configuration
- FETCH_TIMEOUT_EN defined: counter counts WAIT/DRAIN cycles with imem_req & !imem_ready; clears on ready/redirect. At TIMEOUT_CYCLES: fetch_err_o=1 one cycle, flush_o=1, request abandoned, fetch_addr<=EXC_VECTOR, -> WAIT, outputs bubble.
- Undefined: no counter, fetch_err_o tied 0, waits indefinitely.

## Test plan
- Reset, zero-wait memory returning addr^32'h1000 -> imem_addr 0,4,8,...; inst_o 0x1000,0x1004,...; pc_add4_o 4,8,...
- imem_ready delayed 3 cycles on addr 0x8 -> three bubbles (inst_o=0), then inst_o=0x1008, pc_add4_o=0xC.
- stall high 2 cycles while ready returns 0x10 -> inst_o holds prior value, imem_req=0 in HOLD, then inst_o=0x1010.
- branch_taken to 0x200 while request to 0x20 pending -> flush_o=1 that cycle, 0x20 data discarded, next imem_addr=0x200.
- exception, jump (0x300), branch_taken same cycle -> imem_addr=0x8000_0180.
- FETCH_TIMEOUT_EN, imem_ready stuck low -> fetch_err_o pulse after 16 wait cycles, imem_addr=0x8000_0180.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register: PC, imem handshake, stall buffer, redirects.
// Optional FETCH_TIMEOUT_EN macro adds an imem wait-limit that redirects to EXC_VECTOR.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR     = 32'h8000_0180,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        exception,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] pc_add4_o,
   output logic [31:0] inst_o,
   output logic        flush_o,
   output logic        fetch_err_o
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, WAIT, HOLD, DRAIN} state_t;

   state_t            state, state_nxt;
   logic [XLEN-1:0]   fetch_addr, fetch_addr_nxt;
   logic [XLEN-1:0]   pend_target, pend_target_nxt;
   logic [XLEN-1:0]   buf_inst, buf_inst_nxt;
   logic [XLEN-1:0]   buf_pc4, buf_pc4_nxt;
   logic [XLEN-1:0]   inst_nxt, pc4_nxt;
   logic [XLEN-1:0]   addr_pc4_c;
   logic [XLEN-1:0]   target_c;
   logic              redirect_c, waiting_c, timeout_c, to_en_c, err_nxt;
   logic [CNT_W-1:0]  to_cnt;

   assign redirect_c = exception | jump | branch_taken;
   assign target_c   = exception ? EXC_VECTOR : (jump ? jump_target : branch_target);
   assign addr_pc4_c = XLEN'(fetch_addr + 32'd4);
   assign waiting_c  = imem_req & ~imem_ready & ~redirect_c;
   assign timeout_c  = to_en_c & waiting_c & (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign flush_o    = redirect_c | timeout_c;
   assign imem_addr  = fetch_addr;

`ifdef FETCH_TIMEOUT_EN
   assign to_en_c = 1'b1;

   // Counts consecutive unanswered request cycles; ready or redirect restarts it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         to_cnt <= '0;
      else if (!waiting_c || timeout_c)
         to_cnt <= '0;
      else
         to_cnt <= CNT_W'(to_cnt + 1'b1);
   end
`else
   assign to_en_c = 1'b0;
   assign to_cnt  = '0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  state_nxt = WAIT;
         WAIT: begin
            if (redirect_c)
               state_nxt = imem_ready ? WAIT : DRAIN;
            else if (imem_ready && stall)
               state_nxt = HOLD;
         end
         HOLD:  if (redirect_c || !stall) state_nxt = WAIT;
         DRAIN: if ((imem_ready && !redirect_c) || timeout_c) state_nxt = WAIT;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values for the address, buffer and IF/ID-facing registers.
   always_comb begin
      fetch_addr_nxt  = fetch_addr;
      pend_target_nxt = pend_target;
      buf_inst_nxt    = buf_inst;
      buf_pc4_nxt     = buf_pc4;
      inst_nxt        = inst_o;
      pc4_nxt         = pc_add4_o;
      err_nxt         = 1'b0;
      case (state)
         IDLE: begin
            inst_nxt = '0;
            pc4_nxt  = '0;
            if (redirect_c) fetch_addr_nxt = target_c;
         end
         WAIT: begin
            if (redirect_c) begin
               inst_nxt = '0;
               pc4_nxt  = '0;
               if (imem_ready) fetch_addr_nxt  = target_c;
               else            pend_target_nxt = target_c;
            end else if (imem_ready) begin
               fetch_addr_nxt = addr_pc4_c;
               if (stall) begin
                  buf_inst_nxt = imem_rdata;
                  buf_pc4_nxt  = addr_pc4_c;
               end else begin
                  inst_nxt = imem_rdata;
                  pc4_nxt  = addr_pc4_c;
               end
            end else if (timeout_c) begin
               fetch_addr_nxt = EXC_VECTOR;
               err_nxt        = 1'b1;
               inst_nxt       = '0;
               pc4_nxt        = '0;
            end else if (!stall) begin
               inst_nxt = '0;
               pc4_nxt  = '0;
            end
         end
         HOLD: begin
            if (redirect_c) begin
               fetch_addr_nxt = target_c;
               buf_inst_nxt   = '0;
               buf_pc4_nxt    = '0;
               inst_nxt       = '0;
               pc4_nxt        = '0;
            end else if (!stall) begin
               inst_nxt = buf_inst;
               pc4_nxt  = buf_pc4;
            end
         end
         DRAIN: begin
            if (redirect_c) begin
               pend_target_nxt = target_c;
               if (imem_ready) fetch_addr_nxt = target_c;
            end else if (imem_ready) begin
               fetch_addr_nxt = pend_target;
            end else if (timeout_c) begin
               fetch_addr_nxt = EXC_VECTOR;
               err_nxt        = 1'b1;
            end
            if (redirect_c || timeout_c || !stall) begin
               inst_nxt = '0;
               pc4_nxt  = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_addr  <= RESET_PC;
         pend_target <= '0;
         buf_inst    <= '0;
         buf_pc4     <= '0;
         inst_o      <= '0;
         pc_add4_o   <= '0;
         fetch_err_o <= 1'b0;
         imem_req    <= 1'b0;
      end else begin
         fetch_addr  <= fetch_addr_nxt;
         pend_target <= pend_target_nxt;
         buf_inst    <= buf_inst_nxt;
         buf_pc4     <= buf_pc4_nxt;
         inst_o      <= inst_nxt;
         pc_add4_o   <= pc4_nxt;
         fetch_err_o <= err_nxt;
         imem_req    <= (state_nxt == WAIT) || (state_nxt == DRAIN);
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; memory returns addr^0x1000. Define FETCH_TIMEOUT_EN to cover the timeout.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        exception = 1'b0;
   logic        jump = 1'b0;
   logic [31:0] jump_target = '0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        imem_ready = 1'b0;
   logic [31:0] pc_add4_o;
   logic [31:0] inst_o;
   logic        flush_o;
   logic        fetch_err_o;

   int errors = 0;
   int checks = 0;

   localparam logic [31:0] EXC = 32'h8000_0180;

   if_fetch_unit dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .exception     (exception),
      .jump          (jump),
      .jump_target   (jump_target),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .imem_ready    (imem_ready),
      .pc_add4_o     (pc_add4_o),
      .inst_o        (inst_o),
      .flush_o       (flush_o),
      .fetch_err_o   (fetch_err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one cycle's inputs on the falling edge; memory answers the current address.
   task automatic drive(input logic rdy, input logic stl, input logic exc, input logic jmp, input logic br);
      @(negedge clk);
      imem_ready   = rdy;
      imem_rdata   = imem_addr ^ 32'h1000;
      stall        = stl;
      exception    = exc;
      jump         = jmp;
      branch_taken = br;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_ok(input logic [31:0] a);
      logic [31:0] pc4;
      pc4 = 32'(a + 32'd4);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("fetch_addr", imem_addr, a);
      check("fetch_req", 32'(imem_req), 32'd1);
      tick();
      check("fetch_inst", inst_o, a ^ 32'h1000);
      check("fetch_pc4", pc_add4_o, pc4);
   endtask

   initial begin
      #12;
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_inst", inst_o, 32'h0);
      check("rst_pc4", pc_add4_o, 32'h0);
      check("rst_err", 32'(fetch_err_o), 32'd0);
      check("rst_flush", 32'(flush_o), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      check("first_req", 32'(imem_req), 32'd1);
      check("first_addr", imem_addr, 32'h0);

      fetch_ok(32'h0);
      fetch_ok(32'h4);

      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
         check("wait_bubble_inst", inst_o, 32'h0);
         check("wait_bubble_pc4", pc_add4_o, 32'h0);
         check("wait_addr", imem_addr, 32'h8);
      end
      fetch_ok(32'h8);
      fetch_ok(32'hC);

      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check("hold_inst", inst_o, 32'h100C);
      check("hold_pc4", pc_add4_o, 32'h10);
      check("hold_req", 32'(imem_req), 32'd0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check("hold2_inst", inst_o, 32'h100C);
      check("hold2_req", 32'(imem_req), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check("unhold_inst", inst_o, 32'h1010);
      check("unhold_pc4", pc_add4_o, 32'h14);
      check("unhold_addr", imem_addr, 32'h14);
      check("unhold_req", 32'(imem_req), 32'd1);

      fetch_ok(32'h14);
      fetch_ok(32'h18);
      fetch_ok(32'h1C);

      branch_target = 32'h200;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("br_flush", 32'(flush_o), 32'd1);
      tick();
      check("drain_inst", inst_o, 32'h0);
      check("drain_addr", imem_addr, 32'h20);
      check("drain_req", 32'(imem_req), 32'd1);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("drain_flush", 32'(flush_o), 32'd0);
      tick();
      check("discard_inst", inst_o, 32'h0);
      check("br_addr", imem_addr, 32'h200);
      fetch_ok(32'h200);

      jump_target   = 32'h300;
      branch_target = 32'h200;
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      check("prio_flush", 32'(flush_o), 32'd1);
      tick();
      check("prio_addr", imem_addr, EXC);
      check("prio_inst", inst_o, 32'h0);
      fetch_ok(EXC);

      jump_target = 32'hFFFF_FFFC;
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      check("jmp_addr", imem_addr, 32'hFFFF_FFFC);
      fetch_ok(32'hFFFF_FFFC);
      check("wrap_addr", imem_addr, 32'h0);

      jump_target = 32'h40;
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      check("stall_redir_addr", imem_addr, 32'h40);
      check("stall_redir_req", 32'(imem_req), 32'd1);
      check("stall_redir_inst", inst_o, 32'h0);
      fetch_ok(32'h40);

      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check("hold3_inst", inst_o, 32'h1040);
      branch_target = 32'h80;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      check("hold_redir_inst", inst_o, 32'h0);
      check("hold_redir_addr", imem_addr, 32'h80);
      check("hold_redir_req", 32'(imem_req), 32'd1);
      fetch_ok(32'h80);

`ifdef FETCH_TIMEOUT_EN
      for (int i = 0; i < 15; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         check("to_flush_early", 32'(flush_o), 32'd0);
         tick();
         check("to_err_early", 32'(fetch_err_o), 32'd0);
      end
      check("to_addr_early", imem_addr, 32'h84);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("to_flush", 32'(flush_o), 32'd1);
      tick();
      check("to_err", 32'(fetch_err_o), 32'd1);
      check("to_addr", imem_addr, EXC);
      check("to_inst", inst_o, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check("to_err_pulse", 32'(fetch_err_o), 32'd0);
`else
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
         check("no_to_err", 32'(fetch_err_o), 32'd0);
      end
      check("no_to_addr", imem_addr, 32'h84);
      check("no_to_req", 32'(imem_req), 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
